// File: rtl/wb_regfile_sb_pkg.sv
// Shared parameters and helpers for the write-back register file with a
// per-register pending-write scoreboard.
//   DATA_W   : register data width
//   IDX_W    : register index width
//   NUM_REGS : number of architectural registers
//   CNT_W    : width of each pending-write counter
//   CNT_MAX  : saturation value of a pending-write counter
package wb_regfile_sb_pkg;

    localparam int DATA_W   = 64;
    localparam int IDX_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    // A source must wait while its register has an in-flight write, except
    // when the only outstanding write is landing right now: the bypass mux
    // then already delivers the fresh value.
    function automatic logic src_stall(input logic [CNT_W-1:0] cnt,
                                       input logic             wb_hit);
        return (cnt != '0) && !((cnt == CNT_W'(1)) && wb_hit);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter of the scoreboard.
//   clk, reset : clock and synchronous active-low reset
//   inc        : an instruction writing this register was issued
//   dec        : a write-back to this register occurred
//   count      : outstanding writes (0..CNT_MAX)
//   overflow   : combinational, high when an increment is lost at saturation
module sb_counter
    import wb_regfile_sb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // inc and dec together cancel, so only a lone inc can overflow.
    always_comb overflow = inc && !dec && (count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != CNT_MAX) count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            // A write-back with nothing pending is legal; floor at zero.
            if (count != '0) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_regfile_sb.sv
// 32 x 64-bit register file with write-back bypass and a per-register
// pending-write scoreboard that stalls decode on unresolved sources.
//   clk, reset           : clock, synchronous active-low reset
//   WB_WRegEn/WReg1/Dout : write-back port
//   ID_RReg1/ID_RReg2    : decode source indices
//   ID_Issue/ID_DstReg   : decode issues a writer of ID_DstReg
//   ID_RData1/ID_RData2  : combinational read data (with bypass)
//   ID_Stall             : a source still has an in-flight write
//   SB_Err               : sticky counter overflow flag
module wb_regfile_sb
    import wb_regfile_sb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              WB_WRegEn,
    input  logic [IDX_W-1:0]  WB_WReg1,
    input  logic [DATA_W-1:0] WB_Dout,
    input  logic [IDX_W-1:0]  ID_RReg1,
    input  logic [IDX_W-1:0]  ID_RReg2,
    input  logic              ID_Issue,
    input  logic [IDX_W-1:0]  ID_DstReg,
    output logic [DATA_W-1:0] ID_RData1,
    output logic [DATA_W-1:0] ID_RData2,
    output logic              ID_Stall,
    output logic              SB_Err
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] ovf;
    logic                hit1;
    logic                hit2;

    // One-hot issue / write-back decode into the counter array.
    always_comb begin
        inc = '0;
        dec = '0;
        if (ID_Issue)  inc[ID_DstReg] = 1'b1;
        if (WB_WRegEn) dec[WB_WReg1]  = 1'b1;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc[g]),
            .dec      (dec[g]),
            .count    (cnt[g]),
            .overflow (ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (WB_WRegEn) begin
            regs[WB_WReg1] <= WB_Dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)    SB_Err <= 1'b0;
        else if (|ovf) SB_Err <= 1'b1;
    end

    always_comb begin
        hit1 = WB_WRegEn && (WB_WReg1 == ID_RReg1);
        hit2 = WB_WRegEn && (WB_WReg1 == ID_RReg2);
        ID_RData1 = hit1 ? WB_Dout : regs[ID_RReg1];
        ID_RData2 = hit2 ? WB_Dout : regs[ID_RReg2];
        // Counters are registered, so this cycle's issue is not yet visible.
        ID_Stall  = src_stall(cnt[ID_RReg1], hit1) || src_stall(cnt[ID_RReg2], hit2);
    end

endmodule
